pwm_duty_ctrl: RTL and testbench

//   APB3 slave register bank and slew-rate limiter feeding the 3-channel PWM array.

---
 rtl/pwm_duty_ctrl_if.sv | 23 ++
 rtl/pwm_duty_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ctrl_if.sv
// APB3 bus bundle for the PWM duty controller register bank.
interface pwm_duty_ctrl_if #(
    parameter int AW = 8
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// APB3 register bank plus per-channel slew-rate limiter driving three PWM duty inputs.
// Each live duty walks toward its target by STEP counts once per RAMP_DIV+1 clocks.
module pwm_duty_ctrl #(
    parameter int DW    = 16,
    parameter int DIV_W = 16,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    pwm_duty_ctrl_if.slave apb,
    output logic          en,
    output logic [DW-1:0] duty0,
    output logic [DW-1:0] duty1,
    output logic [DW-1:0] duty2,
    output logic [2:0]    ramp_busy
);
    localparam logic [AW-3:0] W_CTRL   = (AW-2)'(0);
    localparam logic [AW-3:0] W_DIV    = (AW-2)'(1);
    localparam logic [AW-3:0] W_STEP   = (AW-2)'(2);
    localparam logic [AW-3:0] W_TGT0   = (AW-2)'(4);
    localparam logic [AW-3:0] W_DUTY0  = (AW-2)'(8);
    localparam logic [AW-3:0] W_STATUS = (AW-2)'(11);

    logic [1:0]       ctrl_reg;
    logic [DIV_W-1:0] ramp_div_reg;
    logic [DW-1:0]    step_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [31:0]      prdata_reg;

    logic [AW-3:0]    word;
    logic             mapped;
    logic             read_only;
    logic [31:0]      rd_data;
    logic             wr_commit;
    logic             wr_ok;
    logic [1:0]       ctrl_next;
    logic             tick;
    logic [DW-1:0]    step_eff;
    logic [DW-1:0]    duty_arr [3];
    logic [DW-1:0]    target_arr [3];

    logic unused_bits;
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[31:DW]};

    assign word      = apb.paddr[AW-1:2];
    assign wr_commit = apb.psel & apb.penable & apb.pwrite;
    assign wr_ok     = wr_commit & mapped & ~read_only;

    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b0;
        rd_data   = 32'd0;
        case (word)
            W_CTRL:          rd_data = {30'd0, ctrl_reg};
            W_DIV:           rd_data = 32'(ramp_div_reg);
            W_STEP:          rd_data = 32'(step_reg);
            W_TGT0:          rd_data = 32'(target_arr[0]);
            W_TGT0 + 1'b1:   rd_data = 32'(target_arr[1]);
            W_TGT0 + 2'd2:   rd_data = 32'(target_arr[2]);
            W_DUTY0:         begin rd_data = 32'(duty_arr[0]); read_only = 1'b1; end
            W_DUTY0 + 1'b1:  begin rd_data = 32'(duty_arr[1]); read_only = 1'b1; end
            W_DUTY0 + 2'd2:  begin rd_data = 32'(duty_arr[2]); read_only = 1'b1; end
            W_STATUS:        begin rd_data = {29'd0, ramp_busy}; read_only = 1'b1; end
            default:         mapped = 1'b0;
        endcase
    end

    assign apb.pready  = 1'b1;
    assign apb.prdata  = prdata_reg;
    assign apb.pslverr = apb.psel & apb.penable & (~mapped | (apb.pwrite & read_only));

    // The duty path reacts to a CTRL write in the commit cycle so that clearing en wins over a tick.
    assign ctrl_next = (wr_ok && word == W_CTRL) ? apb.pwdata[1:0] : ctrl_reg;
    assign tick      = (ctrl_reg == 2'b11) && (cnt_reg == ramp_div_reg);
    assign step_eff  = (step_reg == '0) ? DW'(1) : step_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg     <= '0;
            ramp_div_reg <= '0;
            step_reg     <= '0;
            cnt_reg      <= '0;
            prdata_reg   <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
            if (wr_ok && word == W_DIV)
                ramp_div_reg <= apb.pwdata[DIV_W-1:0];
            if (wr_ok && word == W_STEP)
                step_reg <= apb.pwdata[DW-1:0];
            if (ctrl_reg != 2'b11 || tick || (wr_ok && word == W_DIV))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
            if (apb.psel && !apb.penable)
                prdata_reg <= rd_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : ch
            logic [DW-1:0]        duty_reg;
            logic [DW-1:0]        target_reg;
            logic [DW-1:0]        target_next;
            logic                 tgt_wr;
            logic [DW:0]          sum_w;
            logic signed [DW+1:0] diff_w;
            logic [DW-1:0]        ramp_val;

            assign tgt_wr      = wr_ok && (word == W_TGT0 + (AW-2)'(gi));
            assign target_next = tgt_wr ? apb.pwdata[DW-1:0] : target_reg;
            assign sum_w       = {1'b0, duty_reg} + {1'b0, step_eff};
            assign diff_w      = $signed({2'b00, duty_reg}) - $signed({2'b00, step_eff});

            // Ramp steps clamp at the old target; widened arithmetic prevents wrap either way.
            always_comb begin
                if (duty_reg < target_reg)
                    ramp_val = (sum_w > {1'b0, target_reg}) ? target_reg : sum_w[DW-1:0];
                else
                    ramp_val = (diff_w < $signed({2'b00, target_reg})) ? target_reg : diff_w[DW-1:0];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    target_reg <= '0;
                    duty_reg   <= '0;
                end else begin
                    target_reg <= target_next;
                    if (!ctrl_next[0])
                        duty_reg <= '0;
                    else if (!ctrl_next[1])
                        duty_reg <= target_next;
                    else if (tick)
                        duty_reg <= ramp_val;
                end
            end

            assign duty_arr[gi]   = duty_reg;
            assign target_arr[gi] = target_reg;
            assign ramp_busy[gi]  = (duty_reg != target_reg);
        end
    endgenerate

    assign en    = ctrl_reg[0];
    assign duty0 = duty_arr[0];
    assign duty1 = duty_arr[1];
    assign duty2 = duty_arr[2];
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench: directed scenarios plus random APB traffic against a behavioural model.
module tb_pwm_duty_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en;
    logic [15:0] duty0, duty1, duty2;
    logic [2:0]  ramp_busy;

    pwm_duty_ctrl_if #(.AW(8)) bus ();

    pwm_duty_ctrl #(.DW(16), .DIV_W(16), .AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .apb       (bus.slave),
        .en        (en),
        .duty0     (duty0),
        .duty1     (duty1),
        .duty2     (duty2),
        .ramp_busy (ramp_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, ramp as min/max toward target.
    int m_ctrl, m_div, m_step, m_cnt;
    int m_target [3];
    int m_duty [3];
    int m_prdata;

    function automatic bit m_mapped(input int a);
        int w = a / 4;
        return (w <= 2) || (w >= 4 && w <= 6) || (w >= 8 && w <= 11);
    endfunction

    function automatic bit m_ro(input int a);
        return (a / 4) >= 8;
    endfunction

    function automatic int m_read(input int a);
        case (a / 4)
            0: return m_ctrl;
            1: return m_div;
            2: return m_step;
            4, 5, 6: return m_target[a/4 - 4];
            8, 9, 10: return m_duty[a/4 - 8];
            11: return ((m_duty[0] != m_target[0]) ? 1 : 0) | ((m_duty[1] != m_target[1]) ? 2 : 0)
                     | ((m_duty[2] != m_target[2]) ? 4 : 0);
            default: return 0;
        endcase
    endfunction

    int  n_ctrl;
    int  n_target [3];
    bit  m_tick, div_wr;
    int  s, a, wd;

    always @(posedge clk) begin
        if (reset) begin
            m_ctrl = 0; m_div = 0; m_step = 0; m_cnt = 0; m_prdata = 0;
            for (int i = 0; i < 3; i++) begin m_target[i] = 0; m_duty[i] = 0; end
        end else begin
            a = int'(bus.paddr);
            wd = int'(bus.pwdata & 32'hFFFF);
            m_tick = (m_ctrl == 3) && (m_cnt == m_div);
            div_wr = 0;
            n_ctrl = m_ctrl;
            for (int i = 0; i < 3; i++) n_target[i] = m_target[i];
            if (bus.psel && !bus.penable) m_prdata = m_read(a);
            if (bus.psel && bus.penable && bus.pwrite && m_mapped(a) && !m_ro(a)) begin
                case (a / 4)
                    0: n_ctrl = wd & 3;
                    1: begin m_div = wd; div_wr = 1; end
                    2: m_step = wd;
                    default: n_target[a/4 - 4] = wd;
                endcase
            end
            s = (m_step == 0) ? 1 : m_step;
            for (int i = 0; i < 3; i++) begin
                if ((n_ctrl & 1) == 0) m_duty[i] = 0;
                else if ((n_ctrl & 2) == 0) m_duty[i] = n_target[i];
                else if (m_tick) begin
                    if (m_duty[i] < m_target[i]) m_duty[i] = (m_duty[i] + s < m_target[i]) ? m_duty[i] + s : m_target[i];
                    else m_duty[i] = (m_duty[i] - s > m_target[i]) ? m_duty[i] - s : m_target[i];
                end
            end
            if (m_ctrl != 3 || m_tick || div_wr) m_cnt = 0; else m_cnt++;
            m_ctrl = n_ctrl;
            for (int i = 0; i < 3; i++) m_target[i] = n_target[i];
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("en", 32'(en), 32'(m_ctrl & 1));
            check("duty0", 32'(duty0), m_duty[0]);
            check("duty1", 32'(duty1), m_duty[1]);
            check("duty2", 32'(duty2), m_duty[2]);
            check("ramp_busy", 32'(ramp_busy), m_read(8'h2C));
            check("pready", 32'(bus.pready), 32'd1);
            check("prdata", bus.prdata, m_prdata);
            check("pslverr", 32'(bus.pslverr),
                  32'(bus.psel && bus.penable && (!m_mapped(int'(bus.paddr)) || (bus.pwrite && m_ro(int'(bus.paddr))))));
        end
    end

    logic [31:0] rd_val;
    logic        rd_err;

    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
        @(posedge clk); #1;
        bus.penable = 1;
        @(negedge clk);
        rd_val = bus.prdata;
        rd_err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        if (wr) $display("APB write addr=0x%02h data=0x%0h pslverr=%0d", addr, data, rd_err);
        else    $display("APB read  addr=0x%02h data=0x%0h pslverr=%0d", addr, rd_val, rd_err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] reg_addrs [10] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h28, 8'h2C};
    int vals[$], times[$];
    logic [15:0] prev;
    bit seen_other, found;
    int first_val;

    initial begin
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        @(posedge clk); #1;
        cmp_on = 1;
        idle(2);
        reset = 0;

        // 1: all registers read zero after reset
        for (int i = 0; i < 10; i++) begin
            apb_xfer(0, reg_addrs[i], 0);
            check("reset_read", rd_val, 32'd0);
            check("reset_pslverr", 32'(rd_err), 32'd0);
        end

        // 2: ramp disabled, duty follows target one cycle after commit
        apb_xfer(1, 8'h00, 32'h1);
        apb_xfer(1, 8'h14, 32'd20);
        check("t2_duty1", 32'(duty1), 32'd20);
        check("t2_busy", 32'(ramp_busy), 32'd0);

        // 3: ramp 0 -> 10 in steps of 4, one step per 4 cycles
        apb_xfer(1, 8'h00, 32'h3);
        apb_xfer(1, 8'h04, 32'd3);
        apb_xfer(1, 8'h08, 32'd4);
        apb_xfer(1, 8'h10, 32'd10);
        prev = duty0;
        vals.delete(); times.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (duty0 != prev) begin
                vals.push_back(int'(duty0)); times.push_back(c); prev = duty0;
                if (duty0 == 16'd10) check("t3_busy_falls", 32'(ramp_busy[0]), 32'd0);
            end
        end
        check("t3_nsteps", vals.size(), 32'd3);
        if (vals.size() == 3) begin
            check("t3_step1", vals[0], 32'd4);
            check("t3_step2", vals[1], 32'd8);
            check("t3_step3", vals[2], 32'd10);
            check("t3_gap1", times[1] - times[0], 32'd4);
            check("t3_gap2", times[2] - times[1], 32'd4);
        end

        // 4: large step down clamps at 0, then STEP=0 means 1 per tick
        apb_xfer(1, 8'h00, 32'h1);
        apb_xfer(1, 8'h18, 32'd50);
        check("t4_duty2_preset", 32'(duty2), 32'd50);
        apb_xfer(1, 8'h08, 32'hFFFF);
        apb_xfer(1, 8'h00, 32'h3);
        apb_xfer(1, 8'h18, 32'd0);
        seen_other = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (duty2 != 16'd50 && duty2 != 16'd0) seen_other = 1;
        end
        check("t4_no_wrap_path", 32'(seen_other), 32'd0);
        check("t4_duty2_zero", 32'(duty2), 32'd0);
        apb_xfer(1, 8'h08, 32'd0);
        apb_xfer(1, 8'h18, 32'd3);
        first_val = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (first_val < 0 && duty2 != 16'd0) first_val = int'(duty2);
        end
        check("t4_first_unit_step", first_val, 32'd1);
        check("t4_duty2_final", 32'(duty2), 32'd3);

        // 5: reverse mid-ramp, then disable
        apb_xfer(1, 8'h08, 32'd4);
        apb_xfer(1, 8'h10, 32'd40);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (duty0 >= 16'd18) found = 1;
        end
        check("t5_reached_mid", 32'(found), 32'd1);
        apb_xfer(1, 8'h10, 32'd2);
        idle(100);
        check("t5_clamp_at_2", 32'(duty0), 32'd2);
        apb_xfer(1, 8'h00, 32'h0);
        check("t5_duty0_off", 32'(duty0), 32'd0);
        check("t5_duty1_off", 32'(duty1), 32'd0);
        check("t5_duty2_off", 32'(duty2), 32'd0);
        apb_xfer(0, 8'h10, 0);
        check("t5_target_kept", rd_val, 32'd2);

        // 6: error responses
        apb_xfer(1, 8'h20, 32'h55);
        check("t6_ro_write_err", 32'(rd_err), 32'd1);
        apb_xfer(0, 8'h40, 0);
        check("t6_unmapped_err", 32'(rd_err), 32'd1);
        check("t6_unmapped_data", rd_val, 32'd0);
        apb_xfer(0, 8'h20, 0);
        check("t6_duty0_unchanged", rd_val, 32'd0);
        check("t6_read_ok", 32'(rd_err), 32'd0);

        // Random traffic; the per-cycle compare process checks everything
        for (int t = 0; t < 300; t++) begin
            int pick;
            logic [7:0]  ra;
            logic [31:0] rdat;
            pick = int'($urandom_range(0, 15));
            if (pick < 10) ra = reg_addrs[pick];
            else if (pick < 14) ra = 8'h04 * 8'($urandom_range(0, 3)) + (pick == 13 ? 8'h0C : 8'h10);
            else ra = 8'($urandom_range(0, 255));
            rdat = $urandom;
            if (ra == 8'h04) rdat = rdat & 32'h3;
            if (ra == 8'h08) rdat = rdat & 32'h7;
            if (ra >= 8'h10 && ra <= 8'h1B) rdat = rdat & 32'h3F;
            apb_xfer($urandom_range(0, 1) == 1, ra, rdat);
            idle(int'($urandom_range(0, 5)));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1;
                idle(1);
                reset = 0;
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
